// File: rtl/sloth_op_sequencer.sv
// Operand-set sequencer: loads a0/a1/b0/b1 into r0..r3, runs a stored
// program of 16-bit bitwise register ops, then presents r3..r0 on y3..y0.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an operand set; program memory writable
// EXEC  | executing prog[pc], one instruction per cycle
// DONE  | result held on y3..y0 until the consumer takes it
module sloth_op_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [7:0]       prog_wdata,
    output logic             prog_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y0,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0]    OP_NOP  = 3'd0;
    localparam logic [2:0]    OP_MOV  = 3'd1;
    localparam logic [2:0]    OP_AND  = 3'd2;
    localparam logic [2:0]    OP_OR   = 3'd3;
    localparam logic [2:0]    OP_XOR  = 3'd4;
    localparam logic [2:0]    OP_LNOT = 3'd5;
    localparam logic [2:0]    OP_BNOT = 3'd6;
    localparam logic [2:0]    OP_HALT = 3'd7;
    localparam logic [7:0]    INSN_HALT = 8'hE0;
    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    pc_q;
    logic [WIDTH-1:0] r_q    [4];
    logic [WIDTH-1:0] r_exec [4];
    logic [WIDTH-1:0] opnd_q [4];   // a0, a1, b0, b1 as captured at accept
    logic [WIDTH-1:0] y_q    [4];
    logic [7:0]       prog_q [DEPTH];
    logic             prog_err_q;

    logic [7:0]       insn;
    logic [2:0]       op;
    logic [1:0]       dst;
    logic [2:0]       src;
    logic [WIDTH-1:0] s_val;
    logic [WIDTH-1:0] d_val;
    logic             exec_last;

    assign insn = prog_q[pc_q];
    assign op   = insn[7:5];
    assign dst  = insn[4:3];
    assign src  = insn[2:0];
    assign s_val = src[2] ? opnd_q[src[1:0]] : r_q[src[1:0]];
    assign d_val = r_q[dst];
    assign exec_last = (op == OP_HALT) || (pc_q == PC_LAST);

    // Register file after the current instruction; HALT/NOP leave it untouched.
    always_comb begin
        r_exec = r_q;
        case (op)
            OP_MOV:  r_exec[dst] = s_val;
            OP_AND:  r_exec[dst] = d_val & s_val;
            OP_OR:   r_exec[dst] = d_val | s_val;
            OP_XOR:  r_exec[dst] = d_val ^ s_val;
            OP_LNOT: r_exec[dst] = {{(WIDTH-1){1'b0}}, ~|s_val};
            OP_BNOT: r_exec[dst] = ~s_val;
            default: r_exec[dst] = d_val;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_EXEC;
            S_EXEC:  if (exec_last) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Operand capture, instruction execution and result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
            for (int i = 0; i < 4; i++) begin
                r_q[i]    <= '0;
                opnd_q[i] <= '0;
                y_q[i]    <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    opnd_q[0] <= a0;
                    opnd_q[1] <= a1;
                    opnd_q[2] <= b0;
                    opnd_q[3] <= b1;
                    r_q[0]    <= a0;
                    r_q[1]    <= a1;
                    r_q[2]    <= b0;
                    r_q[3]    <= b1;
                    pc_q      <= '0;
                end
                S_EXEC: begin
                    r_q  <= r_exec;
                    pc_q <= pc_q + 1'b1;
                    if (exec_last) y_q <= r_exec;
                end
                default: ;
            endcase
        end
    end

    // Program memory: host writes land only while idle, otherwise flag them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) prog_q[i] <= INSN_HALT;
            prog_err_q <= 1'b0;
        end else begin
            prog_err_q <= prog_we && (state_q != S_IDLE);
            if (prog_we && (state_q == S_IDLE)) prog_q[prog_addr] <= prog_wdata;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_EXEC);
    assign out_valid = (state_q == S_DONE);
    assign prog_err  = prog_err_q;
    assign y3 = y_q[3];
    assign y2 = y_q[2];
    assign y1 = y_q[1];
    assign y0 = y_q[0];

endmodule

// File: tb/tb_sloth_op_sequencer.sv
// Bench for sloth_op_sequencer: directed scenarios plus randomized programs,
// results checked against a program-level interpreter kept here.
module tb_sloth_op_sequencer;

    localparam int W = 16;
    localparam int D = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prog_we = 1'b0;
    logic [3:0]    prog_addr = '0;
    logic [7:0]    prog_wdata = '0;
    logic          prog_err;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a1 = '0, a0 = '0, b1 = '0, b0 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  y3, y2, y1, y0;
    logic          busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] pm [D];   // expected program memory contents

    sloth_op_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .prog_err(prog_err),
        .in_valid(in_valid), .in_ready(in_ready),
        .a1(a1), .a0(a0), .b1(b1), .b0(b0),
        .out_valid(out_valid), .out_ready(out_ready),
        .y3(y3), .y2(y2), .y1(y1), .y0(y0),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Interpreter: walk the program from address 0 until HALT or the end.
    function automatic logic [63:0] model(input logic [W-1:0] m0, m1, m2, m3,
                                          output int lat);
        logic [W-1:0] r [4];
        logic [W-1:0] opnd [4];
        logic [W-1:0] s;
        logic [2:0]   op;
        int           d;
        r[0] = m0; r[1] = m1; r[2] = m2; r[3] = m3;
        opnd = r;
        lat = D;
        for (int pc = 0; pc < D; pc++) begin
            op = pm[pc][7:5];
            d  = int'(pm[pc][4:3]);
            s  = pm[pc][2] ? opnd[pm[pc][1:0]] : r[pm[pc][1:0]];
            if (op == 3'd7) begin
                lat = pc + 1;
                break;
            end
            case (op)
                3'd1: r[d] = s;
                3'd2: r[d] = r[d] & s;
                3'd3: r[d] = r[d] | s;
                3'd4: r[d] = r[d] ^ s;
                3'd5: r[d] = (s == 0) ? W'(1) : W'(0);
                3'd6: r[d] = ~s;
                default: ;
            endcase
        end
        return {r[3], r[2], r[1], r[0]};
    endfunction

    task automatic wr(input logic [3:0] addr, input logic [7:0] data);
        prog_we = 1'b1; prog_addr = addr; prog_wdata = data;
        step();
        prog_we = 1'b0;
        pm[addr] = data;
        chk("prog_err_idle", 64'(prog_err), 64'd0);
    endtask

    // One transaction: accept, wait for result, optional backpressure, release.
    // we_at >= 0 fires a host write that many cycles into EXEC.
    task automatic run(input logic [W-1:0] va0, va1, vb0, vb1,
                       input int hold, input int we_at);
        int exp_lat;
        int n;
        logic [63:0] exp_y;
        logic [63:0] held;
        exp_y = model(va0, va1, vb0, vb1, exp_lat);
        chk("in_ready_pre", 64'(in_ready), 64'd1);
        a0 = va0; a1 = va1; b0 = vb0; b1 = vb1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a0 = W'($urandom); a1 = W'($urandom); b0 = W'($urandom); b1 = W'($urandom);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            if (n == we_at) begin
                prog_we = 1'b1; prog_addr = 4'd5; prog_wdata = 8'hE0;
            end
            step();
            n++;
            if (we_at >= 0 && n == we_at + 1) begin
                chk("prog_err_pulse", 64'(prog_err), 64'd1);
                prog_we = 1'b0;
            end else if (we_at >= 0 && n == we_at + 2) begin
                chk("prog_err_clear", 64'(prog_err), 64'd0);
            end
            if (out_valid !== 1'b1) chk("busy_exec", 64'(busy), 64'd1);
        end
        chk("latency", 64'(n), 64'(exp_lat));
        chk("y_result", {y3, y2, y1, y0}, exp_y);
        held = {y3, y2, y1, y0};
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            step();
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_y_stable", {y3, y2, y1, y0}, held);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_out_valid", 64'(out_valid), 64'd0);
        chk("release_no_accept", 64'(busy), 64'd0);
        in_valid = 1'b0;
        step();
        chk("idle_after_release", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int len;
        for (int i = 0; i < D; i++) pm[i] = 8'hE0;

        // Reset values, checked while reset is still asserted.
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_prog_err", 64'(prog_err), 64'd0);
        chk("rst_y", {y3, y2, y1, y0}, 64'd0);
        #13 rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Empty program: operands pass straight through.
        run(16'h00FF, 16'h0F0F, 16'h0000, 16'h3333, 0, -1);
        chk("empty_y_literal", {y3, y2, y1, y0}, 64'h3333_0000_0F0F_00FF);

        // AND r3,r1; XOR r3,a0; LNOT r2,b0; BNOT r1,r1; HALT
        wr(4'd0, 8'h59);
        wr(4'd1, 8'h9C);
        wr(4'd2, 8'hB6);
        wr(4'd3, 8'hC9);
        wr(4'd4, 8'hE0);
        run(16'h00FF, 16'h0F0F, 16'h0000, 16'h3333, 10, -1);
        chk("prog_y_literal", {y3, y2, y1, y0}, 64'h03FC_0001_F0F0_00FF);
        run(16'h1234, 16'h0000, 16'hFFFF, 16'hA5A5, 0, -1);

        // Full-depth NOP program, with a dropped write during EXEC.
        for (int i = 0; i < D; i++) wr(4'(i), 8'h00);
        run(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 0, -1);
        chk("nop_y_literal", {y3, y2, y1, y0}, 64'hF00D_CAFE_BEEF_DEAD);
        run(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 2, 3);
        run(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 0, -1);

        // Randomized programs and operands.
        for (int it = 0; it < 24; it++) begin
            len = $urandom_range(0, D);
            for (int k = 0; k < len; k++) wr(4'(k), 8'($urandom));
            if (len < D && $urandom_range(0, 1) == 1) wr(4'(len), 8'hE0);
            run(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                $urandom_range(0, 3), -1);
        end

        // Reset in the middle of EXEC.
        for (int i = 0; i < D; i++) wr(4'(i), 8'h00);
        a0 = 16'h1111; a1 = 16'h2222; b0 = 16'h3333; b1 = 16'h4444;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_y", {y3, y2, y1, y0}, 64'd0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < D; i++) pm[i] = 8'hE0;
        step();
        run(16'h0BAD, 16'hC0DE, 16'h7777, 16'h8888, 0, -1);
        chk("post_rst_passthru", {y3, y2, y1, y0}, 64'h8888_7777_C0DE_0BAD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
